// File: rtl/mux_pkg.sv
// Shared constants and types for the registered 2:1 selector family.
package mux_pkg;

    localparam logic MUX_SEL_A = 1'b0;
    localparam logic MUX_SEL_B = 1'b1;

    localparam int MUX_WORD_W = 8;
    typedef logic [MUX_WORD_W-1:0] mux_word_t;

endpackage : mux_pkg

// File: rtl/mux2to1_en_comb.sv
// Combinational select + enable stage: nxt = en ? (se ? b : a) : 0.
module mux2to1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             se,
    input  logic             en,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = '0;
        if (en) begin
            nxt = (se == MUX_SEL_B) ? b : a;
        end
    end

endmodule : mux2to1_comb

// File: rtl/mux2to1_en.sv
// Registered 2:1 selector with output enable and async active-high reset.
// Build option MUX2TO1_EN_HOLD_EN: y keeps its last value while en=0.
module mux2to1_en
    import mux_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             se,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic             y_vld
);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] y_d, y_q;
    logic             y_vld_d, y_vld_q;

    mux2to1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a   (a),
        .b   (b),
        .se  (se),
        .en  (en),
        .nxt (nxt)
    );

    always_comb begin
        y_vld_d = en;
`ifdef MUX2TO1_EN_HOLD_EN
        y_d = en ? nxt : y_q;
`else
        y_d = nxt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= RST_VAL;
            y_vld_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
        end
    end

    assign y     = y_q;
    assign y_vld = y_vld_q;

endmodule : mux2to1_en

// File: tb/tb_mux2to1_en.sv
// Self-checking bench for mux2to1_en: a 1-bit and an 8-bit instance checked against a reference model.
module tb_mux2to1_en;
    import mux_pkg::*;

    localparam logic [0:0] RST1 = 1'b0;
    localparam mux_word_t  RST8 = 8'h5A;
`ifdef MUX2TO1_EN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       se  = 1'b1;
    logic       en  = 1'b1;
    logic [0:0] a1  = 1'b1;
    logic [0:0] b1  = 1'b1;
    mux_word_t  a8  = 8'hFF;
    mux_word_t  b8  = 8'hFF;
    logic [0:0] y1;
    mux_word_t  y8;
    logic       vld1, vld8;

    int checks = 0;
    int errors = 0;

    mux2to1_en #(.WIDTH(1), .RST_VAL(RST1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .se(se), .en(en), .y(y1), .y_vld(vld1)
    );
    mux2to1_en #(.WIDTH(8), .RST_VAL(RST8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .se(se), .en(en), .y(y8), .y_vld(vld8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each output must show after the most recent event.
    logic [0:0] m_y1;
    mux_word_t  m_y8;
    logic       m_v;
    bit         model_ok = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_y1 = RST1;
                m_y8 = RST8;
                m_v  = 1'b0;
                model_ok = 1'b1;
            end else begin
                if (en && $isunknown(se)) begin
                    checks++;
                    errors++;
                    $display("FAIL se_x: se=%b while en=1 at %0t", se, $time);
                end
                m_v = en;
                if (en) begin
                    m_y1 = se ? b1 : a1;
                    m_y8 = se ? b8 : a8;
                end else if (!HOLD) begin
                    m_y1 = '0;
                    m_y8 = '0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("model_y1", y1, m_y1);
                chk("model_y8", y8, m_y8);
                chk("model_vld1", vld1, m_v);
                chk("model_vld8", vld8, m_v);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // async reset before any clock edge, with all inputs high
        #2 rst = 1'b1;
        #1;
        chk("rst_async_y1", y1, 1'b0);
        chk("rst_async_y8", y8, 8'h5A);
        chk("rst_async_vld", vld1, 1'b0);
        cyc();
        cyc();
        chk("rst_hold_y1", y1, 1'b0);
        chk("rst_hold_y8", y8, 8'h5A);
        chk("rst_hold_vld", vld8, 1'b0);

        // select a
        a1 = 1'b0; b1 = 1'b0; se = MUX_SEL_A; en = 1'b1;
        rst = 1'b0;
        cyc();
        chk("sel_a_00", y1, 1'b0);
        chk("sel_a_00_vld", vld1, 1'b1);
        a1 = 1'b0; b1 = 1'b1;
        cyc();
        chk("sel_a_01", y1, 1'b0);
        a1 = 1'b1; b1 = 1'b0;
        cyc();
        chk("sel_a_10", y1, 1'b1);

        // select b
        a1 = 1'b1; b1 = 1'b0; se = MUX_SEL_B;
        cyc();
        chk("sel_b_10", y1, 1'b0);
        a1 = 1'b0; b1 = 1'b1;
        cyc();
        chk("sel_b_01", y1, 1'b1);
        chk("sel_b_01_vld", vld1, 1'b1);

        // disable
        a1 = 1'b1; b1 = 1'b1; se = 1'b1; en = 1'b0;
        cyc();
        chk("dis_11", y1, HOLD ? 1'b1 : 1'b0);
        chk("dis_11_vld", vld1, 1'b0);
        a1 = 1'b1; b1 = 1'b0; se = 1'b0;
        cyc();
        chk("dis_10", y1, HOLD ? 1'b1 : 1'b0);

        // wide data, se toggling
        a8 = 8'hA5; b8 = 8'h3C; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            se = i[0];
            cyc();
            chk("wide_toggle", y8, i[0] ? 8'h3C : 8'hA5);
        end
        en = 1'b0;
        cyc();
        chk("wide_drop_en", y8, HOLD ? 8'h3C : 8'h00);
        chk("wide_drop_vld", vld8, 1'b0);

        // async reset mid-stream
        en = 1'b1; se = 1'b1;
        cyc();
        chk("mid_pre", y8, 8'h3C);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_y8", y8, 8'h5A);
        chk("mid_rst_vld", vld8, 1'b0);
        #1 rst = 1'b0;
        a8 = 8'h11; b8 = 8'hC3;
        cyc();
        chk("mid_reload", y8, 8'hC3);
        chk("mid_reload_vld", vld8, 1'b1);
        se = 1'b0;
        cyc();
        chk("mid_sel_a", y8, 8'h11);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux2to1_en

// File: doc/mux2to1_en.md
Name: mux2to1_en

Overview:
- Registered 2:1 data selector with active-high output enable.
- Picks operand `a` or `b` by select `se` and registers the result.
- Forces the registered output to zero while disabled.
- Used as a generic steering element in datapaths; one clock domain, no handshake back-pressure.

Parameters:
- WIDTH, 1, bit width of data inputs `a`, `b` and output `y` (legal range 1..64).
- RST_VAL, 0, value loaded into `y` on reset (WIDTH bits, zero-extended/truncated).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  data operand 0, selected when `se`=0.
- b  input  WIDTH  data operand 1, selected when `se`=1.
- se  input  1  select: 0 picks `a`, 1 picks `b`.
- en  input  1  enable: 1 passes the selected operand, 0 forces zero.
- y  output  WIDTH  registered mux result.
- y_vld  output  1  registered copy of `en`; high when `y` carries selected data.

Behaviour:
- Combinational next value: nxt = en ? (se ? b : a) : {WIDTH{1'b0}}.
- On each rising `clk` edge with `rst`=0:
  - y <= nxt
  - y_vld <= en
- Latency: exactly 1 cycle from input change to `y`/`y_vld`. No combinational path from inputs to outputs.
- Reset:
  - `rst` high asynchronously sets y=RST_VAL and y_vld=0, regardless of `clk`.
  - Outputs hold these values while `rst` is high.
  - The first edge after deassertion samples normally.
- Reset mid-operation: any captured value is discarded immediately; no partial update.
- `se` is ignored when `en`=0. In that case `y` is 0 whatever `a`, `b`, `se` are, e.g. a=1, b=1, se=1, en=0 -> y=0.
- Any `se`/`en` combination may change on any cycle; each edge evaluates only the current inputs, with no history.
- X on `se` while `en`=1 is a usage error. The bench flags it; RTL need not resolve it.
- No arithmetic; width handling is bitwise, and every output bit follows the same select.

Optional Feature:
- Macro MUX2TO1_EN_HOLD_EN.
- Defined:
  - When `en`=0, `y` holds its previous registered value instead of clearing to zero.
  - `y_vld` still follows `en`.
  - Reset behaviour is unchanged.
- Undefined (default): `en`=0 clears `y` to zero on the next edge, as described above.

Decomposition:
- Shared package mux_pkg:
  - constant MUX_SEL_A=1'b0
  - constant MUX_SEL_B=1'b1
  - typedef for the default data word (logic [WIDTH-1:0] where used with a fixed width).
- One natural sub-module, mux2to1_comb: a purely combinational select+enable stage producing `nxt`.
- The top level wraps mux2to1_comb with the async-reset output register and the optional hold logic.

Test Plan:
- Reset: assert rst with a=1, b=1, se=1, en=1 -> y=RST_VAL(0), y_vld=0 immediately, with no clock edge needed; both hold until rst drops.
- Select a (WIDTH=1): a=0, b=0, se=0, en=1 -> y=0. Then a=0, b=1, se=0, en=1 -> y=0. Then a=1, b=0, se=0, en=1 -> y=1. Each result appears one edge later with y_vld=1.
- Select b (WIDTH=1): a=1, b=0, se=1, en=1 -> y=0. Then a=0, b=1, se=1, en=1 -> y=1. Each result appears one edge later.
- Disable (WIDTH=1): a=1, b=1, se=1, en=0 -> y=0, y_vld=0. Then a=1, b=0, se=0, en=0 -> y=0. With MUX2TO1_EN_HOLD_EN, y instead keeps its prior value and y_vld=0.
- Wide data (WIDTH=8):
  - a=8'hA5, b=8'h3C, en=1, se toggling every cycle -> y alternates A5/3C, one cycle delayed.
  - Drop en -> y=8'h00 on the next edge.
- Async reset mid-stream: y=8'h3C, then rst pulsed between edges -> y=RST_VAL immediately; after release the next edge loads the current nxt.
